flexka_frame_stack: RTL
=======================

Name: flexka_frame_stack

Overview:
Parametrised LIFO of recursion frames for the Karatsuba controller. Each frame has NFIELDS fields of WIDTH bits (sizes, positions, state, rsize, msize, ...). The top frame lives in a register and is always readable with zero latency. Frames below the top live in a 1-cycle-latency RAM plus a prefetch/forwarding path, so push, pop and replace are each single-cycle and fully back-to-back.

Parameters:
WIDTH, 32, bit width of one frame field
NFIELDS, 10, fields per frame; field 0 = size_A, field 1 = size_B
DEPTH, 64, maximum frames held (top included); power of two, >= 4
PRIM_THRESH, 32, operand size at or below which the base multiplier is used

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
clear  in  1  synchronous flush of stack contents
push  in  1  push push_frame
pop  in  1  pop top frame
push_frame  in  NFIELDS*WIDTH  frame to push; field i at bits [i*WIDTH +: WIDTH]
top_frame  out  NFIELDS*WIDTH  current top frame (registered)
top_base  out  1  registered: top field0 <= PRIM_THRESH or field1 <= PRIM_THRESH
top_c_end  out  WIDTH  registered: field4 + field9 - 1 (pos_C + msize - 1), modulo 2^WIDTH
depth  out  $clog2(DEPTH+1)  frames currently held
empty  out  1  depth == 0
full  out  1  depth == DEPTH
max_depth  out  $clog2(DEPTH+1)  high-water mark of depth since reset
overflow_err  out  1  sticky: push attempted while full
underflow_err  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rstn=0 at posedge): depth=0, empty=1, full=0, max_depth=0, both errors=0, top_frame=0, top_base=0, top_c_end=0. Reset dominates clear, push and pop. RAM contents are not cleared.
- clear (rstn=1): same effect as reset on depth, empty, full, top_frame, top_base and top_c_end. Errors and max_depth are kept. clear overrides push and pop in the same cycle.
- All outputs are registered. An operation sampled at edge t is visible at edge t+1.
- push only, not full: the new top is push_frame, the previous top moves below it, depth+1.
- pop only, not empty: the new top is the frame pushed immediately before the current top, depth-1. Popping to depth 0 leaves top_frame at its last value and sets empty=1.
- push and pop together, not empty: replace. The top becomes push_frame, depth is unchanged, and the frames below are untouched.
- push and pop together while empty: treated as a push; underflow_err is not set.
- push while full (no pop): ignored, state unchanged, overflow_err<=1. push and pop together while full is a legal replace.
- pop while empty (no push): ignored, underflow_err<=1.
- Back-to-back operations in any mix are legal every cycle with no bubbles.
  - The below-top frame must be correct at all times. Implement with a second-from-top register refilled from RAM, plus forwarding when the RAM read address matches the write in flight.
  - The RAM read latency is never visible at the ports.
- top_base and top_c_end are computed from whichever frame becomes the top (pushed, popped or replaced), never from push_frame on a pop.
- max_depth <= max(max_depth, next depth) every cycle.
- Sizes and positions are unsigned. Comparisons are <= on WIDTH bits.

Test Plan:
- Reset, then idle for 3 cycles -> depth=0, empty=1, full=0, top_frame=0, errors=0.
- Push frames F1..F5 (field0 = 100,200,...,500) on consecutive cycles, then pop on 4 consecutive cycles -> top field0 reads 500 after the pushes, then 400, 300, 200, 100 on successive cycles; depth=1; max_depth=5.
- Push F1 (field0=100, field1=40), then push F2 (field0=20) -> top_base=0 after F1, 1 after F2. Pop -> top_base=0. With field4=8 and field9=16, top_c_end=23.
- At depth 3, assert push and pop together with field0=777 -> depth stays 3, top field0=777. Next pop -> the previous frame below top is restored intact.
- Fill to DEPTH=64, push once more -> depth=64, full=1, overflow_err=1, top unchanged. Pop 64 times, then pop again -> empty=1, underflow_err=1.
- Mix: push, push, pop, push, pop, pop with distinct frames (plus clear mid-sequence, plus rstn mid-sequence) -> every pop returns exact LIFO data; clear gives depth=0 with errors kept; rstn gives all outputs at reset values.

Source files
------------

// File: rtl/flexka_frame_stack_if.sv
// Handshake/bus bundle for the Karatsuba recursion frame stack.
// The controller (master) issues clear/push/pop and observes the top frame and status.
interface flexka_frame_stack_if #(
   parameter int WIDTH   = 32,
   parameter int NFIELDS = 10,
   parameter int DEPTH   = 64
) ();
   localparam int FW = NFIELDS * WIDTH;
   localparam int DW = $clog2(DEPTH + 1);

   // Command semantics: clear/push/pop are single-cycle level requests sampled on
   // every rising clk edge; there is no ready, every request is accepted (or ignored
   // and flagged) in the cycle it is sampled, and the result is visible one edge later.
   logic             clear;
   logic             push;
   logic             pop;
   logic [FW-1:0]    push_frame;
   logic [FW-1:0]    top_frame;
   logic             top_base;
   logic [WIDTH-1:0] top_c_end;
   logic [DW-1:0]    depth;
   logic             empty;
   logic             full;
   logic [DW-1:0]    max_depth;
   logic             overflow_err;
   logic             underflow_err;

   modport master (
      output clear, push, pop, push_frame,
      input  top_frame, top_base, top_c_end, depth, empty, full, max_depth,
             overflow_err, underflow_err
   );

   modport slave (
      input  clear, push, pop, push_frame,
      output top_frame, top_base, top_c_end, depth, empty, full, max_depth,
             overflow_err, underflow_err
   );
endinterface

// File: rtl/flexka_frame_stack.sv
// LIFO of Karatsuba recursion frames: registered top, registered second-from-top
// refilled from a 1-cycle RAM prefetch, so push/pop/replace run back-to-back.
module flexka_frame_stack #(
   parameter int WIDTH       = 32,
   parameter int NFIELDS     = 10,
   parameter int DEPTH       = 64,
   parameter int PRIM_THRESH = 32
) (
   input  logic clk,
   input  logic rstn,
   flexka_frame_stack_if.slave sif
);
   localparam int FW = NFIELDS * WIDTH;
   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [FW-1:0]    top_q, top_d;
   logic [FW-1:0]    sec_q, sec_d;
   logic [FW-1:0]    rd_q, rd_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic [DW-1:0]    max_q, max_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             base_q, base_d;
   logic [WIDTH-1:0] cend_q, cend_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [FW-1:0]    mem [DEPTH];

   logic             is_empty, is_full;
   logic             do_push, do_pop, do_repl, load_top;
   logic             we;
   logic [AW-1:0]    waddr, raddr;

   assign is_empty = (depth_q == '0);
   assign is_full  = (depth_q == DW'(DEPTH));

   // push+pop on an empty stack degrades to a push; on a non-empty one it is a replace
   always_comb begin
      do_push = sif.push & (sif.pop ? is_empty : ~is_full);
      do_repl = sif.push & sif.pop & ~is_empty;
      do_pop  = sif.pop & ~sif.push & ~is_empty;
   end

   // The old top is written below when it is pushed down, so RAM[i] holds entry i
   // for every entry under the top; sec_q mirrors RAM[depth-2].
   assign we    = ~sif.clear & do_push & ~is_empty;
   assign waddr = AW'(depth_q - DW'(1));

   always_comb begin
      depth_d  = depth_q;
      top_d    = top_q;
      sec_d    = sec_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      load_top = 1'b0;
      if (sif.clear) begin
         depth_d = '0;
         top_d   = '0;
      end else begin
         if (do_push) begin
            depth_d  = depth_q + DW'(1);
            sec_d    = top_q;
            top_d    = sif.push_frame;
            load_top = 1'b1;
         end
         if (do_repl) begin
            top_d    = sif.push_frame;
            load_top = 1'b1;
         end
         if (do_pop) begin
            depth_d = depth_q - DW'(1);
            // popping the last frame leaves the top register as it was
            if (depth_q > DW'(1)) begin
               top_d    = sec_q;
               sec_d    = rd_q;
               load_top = 1'b1;
            end
         end
         if (sif.push & ~sif.pop & is_full) ovf_d = 1'b1;
         if (sif.pop & ~sif.push & is_empty) unf_d = 1'b1;
      end
   end

   always_comb begin
      base_d = base_q;
      cend_d = cend_q;
      if (sif.clear) begin
         base_d = 1'b0;
         cend_d = '0;
      end else if (load_top) begin
         base_d = (top_d[0 +: WIDTH] <= WIDTH'(PRIM_THRESH)) ||
                  (top_d[WIDTH +: WIDTH] <= WIDTH'(PRIM_THRESH));
         cend_d = top_d[4*WIDTH +: WIDTH] + top_d[9*WIDTH +: WIDTH] - WIDTH'(1);
      end
   end

   always_comb begin
      empty_d = (depth_d == '0);
      full_d  = (depth_d == DW'(DEPTH));
      max_d   = (depth_d > max_q) ? depth_d : max_q;
   end

   // Prefetch the entry that becomes second-from-top if the next cycle pops.
   // Write-first forwarding covers a read hitting the address being written.
   assign raddr = AW'(depth_d - DW'(3));
   always_comb begin
      rd_d = mem[raddr];
      if (we && (waddr == raddr)) rd_d = top_q;
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= top_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         top_q   <= '0;
         sec_q   <= '0;
         rd_q    <= '0;
         depth_q <= '0;
         max_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         base_q  <= 1'b0;
         cend_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         sec_q   <= sec_d;
         rd_q    <= rd_d;
         depth_q <= depth_d;
         max_q   <= max_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         base_q  <= base_d;
         cend_q  <= cend_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign sif.top_frame     = top_q;
   assign sif.top_base      = base_q;
   assign sif.top_c_end     = cend_q;
   assign sif.depth         = depth_q;
   assign sif.empty         = empty_q;
   assign sif.full          = full_q;
   assign sif.max_depth     = max_q;
   assign sif.overflow_err  = ovf_q;
   assign sif.underflow_err = unf_q;
endmodule
